// File: rtl/lii_in_demux_wrapper.sv
// -----------------------------------------------------------------------------
// lii_in_demux_wrapper
// Routes beats from P LII physical input channels to NIN logical HLS input
// streams by their dst id. Each logical stream owns a small FIFO. When several
// channels target the same stream in one cycle, a per-stream round-robin
// pointer picks one. Beats whose dst does not map to a stream are consumed and
// counted. Also produces the kernel clock enable.
//
// Ports:
//   aclk, arstn    clock, asynchronous active-low reset
//   lii_in_tdata   P*PW  phy data, channel p at [p*PW +: PW]; low DW bits used
//   lii_in_tvalid  P     per-channel valid
//   lii_in_tready  P     per-channel ready (combinational from valid/dst)
//   lii_in_src     P*8   source id, reserved, not used for routing
//   lii_in_dst     P*8   destination id per channel
//   m_tdata        NIN*DW stream data, stream i at [i*DW +: DW]
//   m_tvalid       NIN   per-stream valid (registered)
//   m_tready       NIN   per-stream ready from the kernel
//   ce             1     kernel clock enable, low while any stream FIFO is full
//   drop_cnt       16    saturating count of dropped beats
// -----------------------------------------------------------------------------
module lii_in_demux_wrapper #(
  parameter int NIN      = 2,
  parameter int P        = 2,
  parameter int PW       = 128,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int DST_BASE = 0
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic [P*PW-1:0]   lii_in_tdata,
  input  logic [P-1:0]      lii_in_tvalid,
  output logic [P-1:0]      lii_in_tready,
  input  logic [P*8-1:0]    lii_in_src,
  input  logic [P*8-1:0]    lii_in_dst,
  output logic [NIN*DW-1:0] m_tdata,
  output logic [NIN-1:0]    m_tvalid,
  input  logic [NIN-1:0]    m_tready,
  output logic              ce,
  output logic [15:0]       drop_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int PTRW = (P > 1) ? $clog2(P) : 1;
  localparam logic [7:0]      BASE_B  = 8'(DST_BASE);
  localparam logic [7:0]      NIN_B   = 8'(NIN);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [PTRW-1:0] LAST_CH = PTRW'(P - 1);

  // Cyclic channel index: candidate k positions after the round-robin pointer.
  function automatic logic [PTRW-1:0] rr_cand(input logic [PTRW-1:0] ptr, input int k);
    int j;
    j = int'(ptr) + k;
    if (j >= P) begin
      j = j - P;
    end else begin
      j = j;
    end
    return PTRW'(j);
  endfunction

  logic [7:0]      idx_s       [P];
  logic [DW-1:0]   ch_data_s   [P];
  logic [P-1:0]    drop_s;
  logic [P-1:0]    gnt_ch_s;
  logic [NIN-1:0]  push_s;
  logic [NIN-1:0]  pop_s;
  logic [NIN-1:0]  full_s;
  logic [PTRW-1:0] gnt_idx_s   [NIN];
  logic [PTRW-1:0] cand_s;
  logic [DW-1:0]   push_data_s [NIN];
  logic [CW-1:0]   count_nxt_s [NIN];
  logic [16:0]     drop_sum_s;
  logic [15:0]     drop_cnt_nxt_s;

  logic [DW-1:0]   mem_r       [NIN][DEPTH];
  logic [AW-1:0]   wr_ptr_r    [NIN];
  logic [AW-1:0]   rd_ptr_r    [NIN];
  logic [CW-1:0]   count_r     [NIN];
  logic [PTRW-1:0] rr_ptr_r    [NIN];
  logic [NIN-1:0]  m_tvalid_r;
  logic [15:0]     drop_cnt_r;

  // Source id and the unused upper phy bits are reserved; fold them away.
  logic unused_s;
  assign unused_s = ^{lii_in_src, lii_in_tdata};

  // Decode each channel's dst into a stream index; 8-bit wrap makes dst below
  // the base land far out of range, so it drops like any other bad id.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      idx_s[p]     = lii_in_dst[p*8 +: 8] - BASE_B;
      ch_data_s[p] = lii_in_tdata[p*PW +: DW];
      drop_s[p]    = lii_in_tvalid[p] & (idx_s[p] >= NIN_B);
    end
  end

  // Per-stream round-robin grant; a full FIFO grants nobody, even if it pops
  // this cycle, so the push decision never depends on m_tready.
  always_comb begin
    push_s   = '0;
    gnt_ch_s = '0;
    cand_s   = '0;
    for (int i = 0; i < NIN; i++) begin
      gnt_idx_s[i]   = '0;
      push_data_s[i] = '0;
      full_s[i]      = (count_r[i] == DEPTH_C);
      for (int k = 0; k < P; k++) begin
        cand_s = rr_cand(rr_ptr_r[i], k);
        if (!full_s[i] && !push_s[i] && lii_in_tvalid[cand_s] && (idx_s[cand_s] == 8'(i))) begin
          push_s[i]        = 1'b1;
          gnt_idx_s[i]     = cand_s;
          gnt_ch_s[cand_s] = 1'b1;
          push_data_s[i]   = ch_data_s[cand_s];
        end else begin
          push_s[i] = push_s[i];
        end
      end
      pop_s[i]       = m_tvalid_r[i] & m_tready[i];
      count_nxt_s[i] = count_r[i] + CW'(push_s[i]) - CW'(pop_s[i]);
    end
  end

  // Saturating drop counter update; several channels may drop at once.
  always_comb begin
    drop_sum_s = {1'b0, drop_cnt_r};
    for (int p = 0; p < P; p++) begin
      drop_sum_s = drop_sum_s + {16'd0, drop_s[p]};
    end
    if (drop_sum_s[16]) begin
      drop_cnt_nxt_s = 16'hFFFF;
    end else begin
      drop_cnt_nxt_s = drop_sum_s[15:0];
    end
  end

  // FIFO pointers, occupancy, round-robin pointers, valid and drop counter.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < NIN; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        count_r[i]  <= '0;
        rr_ptr_r[i] <= '0;
      end
      m_tvalid_r <= '0;
      drop_cnt_r <= 16'd0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
          rr_ptr_r[i] <= (gnt_idx_s[i] == LAST_CH) ? '0 : gnt_idx_s[i] + PTRW'(1);
        end else begin
          wr_ptr_r[i] <= wr_ptr_r[i];
          rr_ptr_r[i] <= rr_ptr_r[i];
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
        end else begin
          rd_ptr_r[i] <= rd_ptr_r[i];
        end
        count_r[i]    <= count_nxt_s[i];
        m_tvalid_r[i] <= (count_nxt_s[i] != '0);
      end
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  // FIFO storage; cleared on reset so m_tdata reads zero afterwards.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < NIN; i++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_r[i][d] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (push_s[i]) begin
          mem_r[i][wr_ptr_r[i]] <= push_data_s[i];
        end else begin
          mem_r[i][wr_ptr_r[i]] <= mem_r[i][wr_ptr_r[i]];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NIN; gi++) begin : g_out
    assign m_tdata[gi*DW +: DW] = mem_r[gi][rd_ptr_r[gi]];
  end

  assign m_tvalid      = m_tvalid_r;
  assign drop_cnt      = drop_cnt_r;
  assign lii_in_tready = lii_in_tvalid & (drop_s | gnt_ch_s);
  assign ce            = ~(|full_s);

endmodule

// File: tb/tb_lii_in_demux_wrapper.sv
module tb_lii_in_demux_wrapper;

  localparam int NIN = 2, P = 2, PW = 128, DW = 32, DEPTH = 4, BASE = 3;

  logic              aclk = 1'b0;
  logic              arstn;
  logic [P*PW-1:0]   tdata;
  logic [P-1:0]      tvalid;
  logic [P-1:0]      tready;
  logic [P*8-1:0]    src;
  logic [P*8-1:0]    dst;
  logic [NIN*DW-1:0] m_tdata;
  logic [NIN-1:0]    m_tvalid;
  logic [NIN-1:0]    m_tready;
  logic              ce;
  logic [15:0]       drop_cnt;

  lii_in_demux_wrapper #(.NIN(NIN), .P(P), .PW(PW), .DW(DW), .DEPTH(DEPTH), .DST_BASE(BASE)) dut (
    .aclk(aclk), .arstn(arstn),
    .lii_in_tdata(tdata), .lii_in_tvalid(tvalid), .lii_in_tready(tready),
    .lii_in_src(src), .lii_in_dst(dst),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .ce(ce), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  // Reference model: per-stream queues, round-robin pointers, drop total.
  logic [31:0] mq [NIN][$];
  int          mrr [NIN];
  int          mdrop;
  logic [P-1:0] exp_rdy;
  logic [31:0] dq1 [$];
  bit          rec1;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < NIN; i++) begin
      mq[i].delete();
      mrr[i] = 0;
    end
    mdrop = 0;
  endtask

  task automatic setch(input int p, input logic v, input logic [7:0] d, input logic [31:0] data);
    tvalid[p]        = v;
    dst[p*8 +: 8]    = d;
    src[p*8 +: 8]    = 8'($urandom);
    tdata[p*PW +: PW] = {$urandom, $urandom, $urandom, data};
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic step(input string tag);
    int idx;
    int j;
    int gsel [NIN];
    logic [P-1:0] drp;
    logic [P-1:0] gnt;
    bit all_room;
    #1;
    drp = '0;
    gnt = '0;
    all_room = 1'b1;
    for (int p = 0; p < P; p++) begin
      idx = (int'(dst[p*8 +: 8]) - BASE) & 255;
      drp[p] = tvalid[p] && (idx >= NIN);
    end
    for (int i = 0; i < NIN; i++) begin
      gsel[i] = -1;
      if (mq[i].size() >= DEPTH) all_room = 1'b0;
      if (mq[i].size() < DEPTH) begin
        for (int k = 0; k < P; k++) begin
          j = (mrr[i] + k) % P;
          if (gsel[i] < 0 && tvalid[j] && (((int'(dst[j*8 +: 8]) - BASE) & 255) == i)) gsel[i] = j;
        end
      end
      if (gsel[i] >= 0) gnt[gsel[i]] = 1'b1;
    end
    exp_rdy = drp | gnt;
    chk({tag, "/tready"}, 64'(tready), 64'(exp_rdy));
    chk({tag, "/ce"}, 64'(ce), 64'(all_room));
    chk({tag, "/drop_cnt"}, 64'(drop_cnt), 64'(mdrop));
    for (int i = 0; i < NIN; i++) begin
      chk($sformatf("%s/m_tvalid%0d", tag, i), 64'(m_tvalid[i]), 64'(mq[i].size() != 0));
      if (mq[i].size() != 0)
        chk($sformatf("%s/m_tdata%0d", tag, i), 64'(m_tdata[i*DW +: DW]), 64'(mq[i][0]));
    end
    if (rec1 && m_tvalid[1] && m_tready[1]) dq1.push_back(m_tdata[DW +: DW]);
    for (int i = 0; i < NIN; i++) begin
      if (mq[i].size() != 0 && m_tready[i]) void'(mq[i].pop_front());
      if (gsel[i] >= 0) begin
        mq[i].push_back(tdata[gsel[i]*PW +: 32]);
        mrr[i] = (gsel[i] + 1) % P;
      end
    end
    mdrop = mdrop + $countones(drp);
    if (mdrop > 65535) mdrop = 65535;
    @(negedge aclk);
  endtask

  initial begin
    logic [P-1:0] hold;
    int v;
    arstn = 1'b0; tvalid = '0; dst = '0; tdata = '0; src = '0; m_tready = '0; rec1 = 1'b0;
    mreset();

    // Reset state; tready is combinational even in reset.
    #2;
    setch(0, 1'b1, 8'(BASE), 32'h1);
    setch(1, 1'b1, 8'(BASE + 1), 32'h2);
    #1;
    chk("rst/tready", 64'(tready), 64'h3);
    chk("rst/m_tvalid", 64'(m_tvalid), 64'h0);
    chk("rst/m_tdata", 64'(m_tdata), 64'h0);
    chk("rst/drop_cnt", 64'(drop_cnt), 64'h0);
    chk("rst/ce", 64'(ce), 64'h1);
    tvalid = '0;
    @(negedge aclk);
    @(negedge aclk);
    arstn = 1'b1;

    // Single beat to stream 1, visible the next cycle.
    setch(0, 1'b1, 8'(BASE + 1), 32'hDEADBEEF);
    step("single");
    chk("single/rdy0", 64'(exp_rdy), 64'h1);
    tvalid = '0;
    m_tready = 2'b10;
    step("single_out");
    m_tready = '0;

    // Contention on stream 0: grants must alternate ch0, ch1.
    m_tready = 2'b01;
    setch(0, 1'b1, 8'(BASE), 32'h100);
    setch(1, 1'b1, 8'(BASE), 32'h200);
    for (int n = 1; n <= 8; n++) begin
      step("contend");
      chk("contend/alt", 64'(exp_rdy), (n % 2 == 1) ? 64'h1 : 64'h2);
      for (int p = 0; p < P; p++)
        if (exp_rdy[p]) setch(p, 1'b1, 8'(BASE), 32'(p * 256 + 256 + n));
    end
    tvalid = '0;
    for (int n = 0; n < 3; n++) step("contend_drain");

    // Fill stream 0 with no kernel ready, then one pop frees a slot.
    m_tready = '0;
    for (int n = 0; n < 7; n++) begin
      if (!tvalid[0] || exp_rdy[0]) setch(0, 1'b1, 8'(BASE), 32'h300 + 32'(n));
      step("fill");
    end
    chk("fill/ce_low", 64'(ce), 64'h0);
    m_tready = 2'b01;
    step("fill_pop");
    m_tready = '0;
    step("fill_resume");
    tvalid = '0;
    m_tready = 2'b01;
    for (int n = 0; n < 6; n++) step("fill_drain");

    // Drop on ch0 and parallel route on ch1, then saturate the counter.
    setch(0, 1'b1, 8'(BASE + 5), 32'h400);
    setch(1, 1'b1, 8'(BASE), 32'h401);
    step("drop_par");
    tvalid = '0;
    step("drop_par_out");
    setch(0, 1'b1, 8'(BASE + 7), 32'h0);
    setch(1, 1'b1, 8'(BASE - 1), 32'h0);
    for (int n = 0; n < 32770; n++) step("drop_sat");
    tvalid = '0;
    step("drop_sat_end");
    chk("drop_sat/value", 64'(drop_cnt), 64'hFFFF);

    // Asynchronous reset with both FIFOs partly filled.
    m_tready = '0;
    setch(0, 1'b1, 8'(BASE), 32'h500);
    setch(1, 1'b1, 8'(BASE + 1), 32'h600);
    step("prefill");
    setch(0, 1'b1, 8'(BASE), 32'h501);
    setch(1, 1'b1, 8'(BASE + 1), 32'h601);
    step("prefill");
    tvalid = '0;
    #2 arstn = 1'b0;
    #1;
    chk("arst/m_tvalid", 64'(m_tvalid), 64'h0);
    chk("arst/drop_cnt", 64'(drop_cnt), 64'h0);
    chk("arst/m_tdata", 64'(m_tdata), 64'h0);
    mreset();
    @(negedge aclk);
    arstn = 1'b1;
    setch(1, 1'b1, 8'(BASE + 1), 32'hA5A5_0001);
    step("post_rst");
    tvalid = '0;
    step("post_rst_out");
    chk("post_rst/alone", 64'(m_tvalid), 64'h2);
    m_tready = 2'b11;
    step("post_rst_drain");

    // Stream 1 carries 0..19 while the kernel ready toggles every cycle.
    rec1 = 1'b1;
    v = 0;
    setch(0, 1'b1, 8'(BASE + 1), 32'(v));
    for (int c = 0; c < 200 && dq1.size() < 20; c++) begin
      m_tready = {c[0], 1'b0};
      step("wrap");
      if (exp_rdy[0]) begin
        v++;
        if (v < 20) setch(0, 1'b1, 8'(BASE + 1), 32'(v));
        else tvalid[0] = 1'b0;
      end
    end
    rec1 = 1'b0;
    tvalid = '0;
    chk("wrap/count", 64'(dq1.size()), 64'd20);
    for (int n = 0; n < dq1.size(); n++) chk($sformatf("wrap/val%0d", n), 64'(dq1[n]), 64'(n));
    m_tready = 2'b11;
    for (int n = 0; n < 6; n++) step("wrap_drain");

    // Random traffic; a channel that was not accepted holds its beat.
    hold = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < P; p++) begin
        if (!hold[p]) begin
          case ($urandom_range(0, 3))
            0: setch(p, 1'($urandom), 8'(BASE), $urandom);
            1: setch(p, 1'($urandom), 8'(BASE + 1), $urandom);
            2: setch(p, 1'($urandom), 8'(BASE + 2), $urandom);
            default: setch(p, 1'($urandom), 8'(BASE - 1), $urandom);
          endcase
        end
      end
      m_tready = 2'($urandom);
      step("rand");
      hold = tvalid & ~exp_rdy;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lii_in_demux_wrapper.md
Name: lii_in_demux_wrapper

Overview:
- Parametrised successor to the single-channel input wrapper. Accepts P LII physical input channels and routes each beat by its dst field to one of NIN logical HLS input streams.
- Each logical stream has its own FIFO. Arbitration is round-robin when several phy channels target the same stream in one cycle.
- Beats with an out-of-range dst are dropped and counted.
- Generates the kernel clock enable. Sits between the LII fabric and the HLS kernel's input AXI-Stream ports.

Parameters:
- NIN, 2, number of logical output streams (1..16).
- P, 2, number of phy input channels (1..8).
- PW, 128, phy packing width.
- DW, 32, logical stream data width; DW <= PW.
- DEPTH, 4, per-stream FIFO depth; power of two, >= 2.
- DST_BASE, 0, dst id mapped to stream 0; stream i is addressed by DST_BASE+i.

Ports:
- aclk, in, 1, clock.
- arstn, in, 1, asynchronous active-low reset.
- lii_in_tdata, in, P*PW, phy data; channel p occupies [p*PW +: PW].
- lii_in_tvalid, in, P, per-channel valid.
- lii_in_tready, out, P, per-channel ready.
- lii_in_src, in, P*8, source id; ignored by routing, reserved.
- lii_in_dst, in, P*8, destination id per channel.
- m_tdata, out, NIN*DW, stream i occupies [i*DW +: DW].
- m_tvalid, out, NIN, per-stream valid.
- m_tready, in, NIN, per-stream ready from kernel.
- ce, out, 1, kernel clock enable.
- drop_cnt, out, 16, count of dropped beats.

Behaviour:
- Clock and reset: single clock aclk. Reset is asynchronous, active-low on arstn. All state clears on arstn=0, including mid-transfer; in-flight FIFO contents are discarded.
- Reset values: m_tvalid=0, m_tdata=0, drop_cnt=0, all FIFO counts=0, all RR pointers=0. lii_in_tready follows its combinational equation: with FIFOs empty, it is 1 for any channel whose tvalid=1.
- Decode: idx_p = dst_p - DST_BASE, computed as 8-bit unsigned wrap. Channel p is valid-routed when idx_p < NIN.
- Drop path: a channel with tvalid=1 and a non-routed dst has tready=1. The beat is consumed and drop_cnt increments, saturating at 0xFFFF. If k channels drop in the same cycle, drop_cnt += k (saturating).
- Arbitration, per stream i:
  - Requesters are the channels with tvalid=1 and idx_p==i.
  - If FIFO i is not full, grant the first requester at or after rr_ptr[i] (cyclic over 0..P-1).
  - On grant, rr_ptr[i] <= granted+1 mod P. Without a grant, rr_ptr[i] holds.
  - At most one push per stream per cycle. Different streams can each accept one beat in the same cycle.
- Ready: lii_in_tready[p] = tvalid_p & (dropped_p | granted_p). Ready may depend combinationally on tvalid/dst. A non-granted channel holds its beat; the LII source must keep data stable.
- Push: on a granted handshake, write lii_in_tdata[p*PW +: DW] (low DW bits) into FIFO i.
- Full rule: push is allowed only when count<DEPTH. A pop in the same cycle does not free space for a push in that cycle. When full, no grant is given and requesters stall.
- Pop: m_tvalid[i] = (count_i != 0), registered. m_tdata[i] is the head entry. Pop occurs on m_tvalid & m_tready. Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
- Latency: a beat accepted in cycle N appears on m_tvalid/m_tdata in cycle N+1 (FIFO was empty, no bypass).
- Ordering: order is preserved per source channel per stream. There is no ordering guarantee between channels.
- Pointer wrap: FIFO read and write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- ce: ce = AND over i of (count_i < DEPTH), combinational. It is 1 out of reset and drops in the cycle any stream FIFO is full.
- lii_in_src: unused and does not affect behaviour.

Test Plan:
- Reset then single beat: reset, then ch0 dst=DST_BASE+1, data 0xDEADBEEF -> tready[0]=1 in same cycle; m_tvalid[1]=1, m_tdata[1]=0xDEADBEEF next cycle; stream 0 untouched; ce=1 throughout.
- Contention fairness: ch0 and ch1 both hold dst=stream 0 continuously, m_tready[0]=1 -> grants alternate ch0,ch1,ch0,ch1 (starting ch0 from reset); one push per cycle; output data interleaves accordingly.
- Full/backpressure: m_tready[0]=0, push 4 beats (DEPTH=4) -> count=4, ce=0, tready for further stream-0 beats=0. Raise m_tready for one cycle -> pop, no push that cycle; next cycle push resumes and ce returns to 1.
- Drop and parallel routing: ch0 dst=DST_BASE+5 (NIN=2), ch1 dst=DST_BASE+0 same cycle -> both tready=1; drop_cnt=1; stream 0 receives ch1 data. Repeat drop 0x10000 times -> drop_cnt saturates at 0xFFFF.
- Reset mid-operation: FIFOs partially full, arstn low mid-cycle -> m_tvalid=0 and drop_cnt=0 asynchronously; after release, first new beat emerges alone with N+1 latency.
- Wrap-around: stream 1 streams 20 sequential values (0..19) with m_tready toggling 1/0 every cycle -> output order 0..19 exactly, no loss or duplication across pointer wraps.
